// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed up in a final cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [2:0]       op,
   input  logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

   stateT            stateReg, stateNext;
   logic [CW-1:0]    countReg;
   logic             isDivReg, negResReg, negRemReg, divZeroReg;
   logic [WIDTH-1:0] origAReg, operandReg, accHiReg, accLoReg;
   logic [WIDTH-1:0] hiReg, loReg;

   logic               accept, signedOp;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH:0]     mulSum, mulPick, divShift, divDiff;
   logic [WIDTH-1:0]   iterHi, iterLo;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   fixHi, fixLo;

   assign accept   = (stateReg == IDLE) && start && !op[2];
   assign signedOp = !op[0];
   assign magA     = (signedOp && srcA[WIDTH-1]) ? (~srcA + WIDTH'(1)) : srcA;
   assign magB     = (signedOp && srcB[WIDTH-1]) ? (~srcB + WIDTH'(1)) : srcB;

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (accept) stateNext = RUN;
         RUN:     if (countReg == LAST) stateNext = FIX;
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // accHi/accLo hold {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mulSum   = {1'b0, accHiReg} + {1'b0, operandReg};
      mulPick  = accLoReg[0] ? mulSum : {1'b0, accHiReg};
      divShift = {accHiReg, accLoReg[WIDTH-1]};
      divDiff  = divShift - {1'b0, operandReg};
      if (isDivReg) begin
         iterHi = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
         iterLo = {accLoReg[WIDTH-2:0], !divDiff[WIDTH]};
      end else begin
         iterHi = mulPick[WIDTH:1];
         iterLo = {mulPick[0], accLoReg[WIDTH-1:1]};
      end
   end

   always_comb begin
      prodFix = {accHiReg, accLoReg};
      if (negResReg) prodFix = -prodFix;
      fixHi = prodFix[2*WIDTH-1:WIDTH];
      fixLo = prodFix[WIDTH-1:0];
      if (isDivReg) begin
         if (divZeroReg) begin
            fixHi = origAReg;
            fixLo = '1;
         end else begin
            fixHi = negRemReg ? -accHiReg : accHiReg;
            fixLo = negResReg ? -accLoReg : accLoReg;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stateReg   <= IDLE;
         countReg   <= '0;
         isDivReg   <= 1'b0;
         negResReg  <= 1'b0;
         negRemReg  <= 1'b0;
         divZeroReg <= 1'b0;
         origAReg   <= '0;
         operandReg <= '0;
         accHiReg   <= '0;
         accLoReg   <= '0;
         hiReg      <= '0;
         loReg      <= '0;
      end else begin
         stateReg <= stateNext;
         case (stateReg)
            IDLE: begin
               if (accept) begin
                  countReg   <= '0;
                  isDivReg   <= op[1];
                  negResReg  <= signedOp && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                  negRemReg  <= signedOp && srcA[WIDTH-1];
                  divZeroReg <= (srcB == '0);
                  origAReg   <= srcA;
                  operandReg <= magB;
                  accHiReg   <= '0;
                  accLoReg   <= magA;
               end else if (start && op == 3'b100) begin
                  hiReg <= srcA;
               end else if (start && op == 3'b101) begin
                  loReg <= srcA;
               end
            end
            RUN: begin
               // counter parks at its last value rather than wrapping
               if (countReg != LAST) countReg <= countReg + CW'(1);
               accHiReg <= iterHi;
               accLoReg <= iterLo;
            end
            FIX: begin
               hiReg <= fixHi;
               loReg <= fixLo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (stateReg != IDLE);
   assign hi   = hiReg;
   assign lo   = loReg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO, a monitor checks on each busy fall.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        resetN = 1'b1;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic [2:0]  op = '0;
   logic        start = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } expT;

   expT sb[$];
   int  passCnt = 0;
   int  checkCnt = 0;
   bit  abortPending = 1'b0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .resetN(resetN), .srcA(srcA), .srcB(srcB),
      .op(op), .start(start), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic waitIdle(input string nm);
      int n = 0;
      while (busy && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, " completes"}, 64'(busy), 64'd0);
   endtask

   task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; srcA = a; srcB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic runOp(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo);
      sb.push_back('{eHi, eLo, nm});
      pulse(o, a, b);
      srcA = $urandom; srcB = $urandom; op = 3'($urandom_range(0, 7));
      waitIdle(nm);
   endtask

   // monitor: counts busy cycles, watches hi/lo stay frozen, compares on completion
   initial begin
      bit prevBusy = 1'b0;
      bit moved = 1'b0;
      int busyCnt = 0;
      logic [31:0] runHi = '0, runLo = '0;
      expT e;
      forever begin
         @(negedge clk);
         if (busy) begin
            if (!prevBusy) begin
               busyCnt = 0; runHi = hi; runLo = lo; moved = 1'b0;
            end
            busyCnt++;
            if (hi !== runHi || lo !== runLo) moved = 1'b1;
         end else if (prevBusy) begin
            if (abortPending) begin
               abortPending = 1'b0;
            end else if (sb.size() == 0) begin
               check("spurious completion", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, " hi"}, 64'(hi), 64'(e.hi));
               check({e.name, " lo"}, 64'(lo), 64'(e.lo));
               check({e.name, " busy cycles"}, 64'(busyCnt), 64'd33);
               check({e.name, " hi/lo held during run"}, 64'(moved), 64'd0);
               $display("txn %s: hi=%h lo=%h busy=%0d", e.name, hi, lo, busyCnt);
            end
         end
         prevBusy = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 resetN = 1'b0;
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      $display("txn reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      @(posedge clk); #1;

      runOp("MULTU max*max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      runOp("MULT -3*5",     3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
      runOp("MULT min*min",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      runOp("MULTU 2^16*2^16", 3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
      runOp("DIV -7/2",      3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("DIV 7/-2",      3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      runOp("DIVU 100/0",    3'b011, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
      runOp("DIV -7/0",      3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      runOp("DIV min/-1",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      runOp("DIVU max/10",   3'b011, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999);

      // starts while busy must be ignored, including MTHI
      sb.push_back('{32'h0, 32'h2A, "MULTU 7*6 with ignored starts"});
      pulse(3'b001, 32'd7, 32'd6);
      repeat (4) begin @(posedge clk); #1; end
      pulse(3'b100, 32'hAAAA5555, 32'h0);
      repeat (4) begin @(posedge clk); #1; end
      pulse(3'b001, 32'd3, 32'd3);
      waitIdle("MULTU 7*6");

      pulse(3'b101, 32'h00001234, 32'h0);
      check("MTLO lo", 64'(lo), 64'h1234);
      check("MTLO hi kept", 64'(hi), 64'h0);
      check("MTLO busy", 64'(busy), 64'd0);
      $display("txn MTLO: hi=%h lo=%h", hi, lo);

      pulse(3'b100, 32'hCAFEF00D, 32'h0);
      check("MTHI hi", 64'(hi), 64'hCAFEF00D);
      check("MTHI lo kept", 64'(lo), 64'h1234);
      $display("txn MTHI: hi=%h lo=%h", hi, lo);

      pulse(3'b110, 32'h0000FFFF, 32'h0000FFFF);
      @(posedge clk); #1;
      check("NOP busy", 64'(busy), 64'd0);
      check("NOP hi/lo", {hi, lo}, {32'hCAFEF00D, 32'h00001234});
      $display("txn NOP: hi=%h lo=%h", hi, lo);

      // asynchronous reset mid-run: no clock edge between assert and check
      pulse(3'b011, 32'd100, 32'd7);
      repeat (15) begin @(posedge clk); #1; end
      check("busy before abort", 64'(busy), 64'd1);
      abortPending = 1'b1;
      resetN = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort hi", 64'(hi), 64'd0);
      check("abort lo", 64'(lo), 64'd0);
      $display("txn abort: busy=%0b hi=%h lo=%h", busy, hi, lo);
      #1 resetN = 1'b1;
      @(posedge clk); #1;
      runOp("DIVU 100/7 after reset", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
